mac_share_sched: RTL and testbench

Time-shares one 8x8 Dadda multiply-accumulate datapath (RES = A*B + M, 17-bit) between NUM_REQ requesters. Each requester has its own operand port. A round-robin arbiter picks one request per cycle and registers its operands into the datapath. The result is registered and returned on a single tagged response channel with backpressure. The block sits between the multiplier core and its client blocks, and it instantiates the core internally.

---
 rtl/mac_share_sched_pkg.sv | 30 +++
 rtl/mac_share_sched_core.sv | 28 ++
 rtl/mac_share_sched_rr_arbiter.sv | 40 ++++
 rtl/mac_share_sched.sv | 117 +++++++++++
 tb/tb_mac_share_sched.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mac_share_sched_pkg.sv
// Shared widths, pipeline record types and small helpers for the shared
// multiply-accumulate scheduler.
package mac_share_sched_pkg;

    localparam int OPA_W = 8;
    localparam int OPB_W = 8;
    localparam int ADD_W = 16;
    localparam int RES_W = 17;
    // Internal tag width, wide enough for the largest legal requester count (8).
    localparam int TAG_W = 3;

    typedef struct packed {
        logic [OPA_W-1:0] a;
        logic [OPB_W-1:0] b;
        logic [ADD_W-1:0] m;
        logic [TAG_W-1:0] id;
        logic             valid;
    } stage_t;

    typedef struct packed {
        logic [RES_W-1:0] res;
        logic [TAG_W-1:0] id;
    } rsp_t;

    function automatic logic [TAG_W-1:0] wrap_inc(input logic [TAG_W-1:0] idx,
                                                  input int unsigned       n);
        return (idx == TAG_W'(n - 1)) ? '0 : idx + TAG_W'(1);
    endfunction

endpackage

// File: rtl/mac_share_sched_core.sv
// 8x8 multiply-accumulate core: res = a*b + m + cin, unsigned, as a sum of
// shifted partial products that synthesis maps onto its reduction tree.
module mac_share_sched_core
    import mac_share_sched_pkg::*;
(
    input  logic [OPA_W-1:0] a,
    input  logic [OPB_W-1:0] b,
    input  logic [ADD_W-1:0] m,
    input  logic             cin,
    output logic [RES_W-1:0] res
);

    logic [RES_W-1:0] acc;

    // NOTE: combinational blocks assign a default to every output first so no
    // path leaves a value unassigned, which would infer a latch.
    always_comb begin
        acc = RES_W'(m) + RES_W'(cin);
        for (int i = 0; i < OPB_W; i++) begin
            if (b[i]) begin
                acc = acc + (RES_W'(a) << i);
            end
        end
    end

    assign res = acc;

endmodule

// File: rtl/mac_share_sched_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr wins; the one-hot
// grant is suppressed when en is low but gnt_idx still reports the winner.
module mac_share_sched_rr_arbiter
    import mac_share_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    input  logic [TAG_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [TAG_W-1:0] gnt_idx
);

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic           found;
    int             sel;
    int             sum;

    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
        found   = 1'b0;
        sel     = 0;
        for (int j = 0; j < N; j++) begin
            if (!found && req_rot[j]) begin
                found = 1'b1;
                sel   = j;
            end
        end
        sum = int'(ptr) + sel;
        if (sum >= N) begin
            sum = sum - N;
        end
        gnt_idx = TAG_W'(sum);
        gnt     = (found && en) ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/mac_share_sched.sv
// Time-shares one multiply-accumulate core between NUM_REQ requesters through
// a two-stage (operand, result) pipeline with a tagged, backpressured response.
module mac_share_sched
    import mac_share_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*OPA_W-1:0] req_a,
    input  logic [NUM_REQ*OPB_W-1:0] req_b,
    input  logic [NUM_REQ*ADD_W-1:0] req_m,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [RES_W-1:0]         rsp_res,
    output logic [ID_W-1:0]          rsp_id,
    output logic                     busy,
    output logic [CNT_W-1:0]         op_count
);

    stage_t           s1_q, s1_d, s1_sel;
    rsp_t             s2_q, s2_d;
    logic             s2_valid_q, s2_valid_d;
    logic [TAG_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] op_count_q, op_count_d;

    logic             s2_load, s1_free, arb_en, grant_any;
    logic [NUM_REQ-1:0] gnt;
    logic [TAG_W-1:0] gnt_idx;
    logic [RES_W-1:0] core_res;

    assign s2_load   = s1_q.valid & (~s2_valid_q | rsp_ready);
    assign s1_free   = ~s1_q.valid | s2_load;
    // Gating with rst_n keeps req_ready low for the whole time reset is held.
    assign arb_en    = s1_free & rst_n;
    assign grant_any = |gnt;

    mac_share_sched_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    mac_share_sched_core u_core (
        .a   (s1_q.a),
        .b   (s1_q.b),
        .m   (s1_q.m),
        .cin (1'b0),
        .res (core_res)
    );

    always_comb begin
        s1_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                s1_sel.a = req_a[i*OPA_W +: OPA_W];
                s1_sel.b = req_b[i*OPB_W +: OPB_W];
                s1_sel.m = req_m[i*ADD_W +: ADD_W];
            end
        end
        s1_sel.id    = gnt_idx;
        s1_sel.valid = 1'b1;

        s1_d = s1_q;
        if (s2_load) begin
            s1_d.valid = 1'b0;
        end
        if (grant_any) begin
            s1_d = s1_sel;
        end

        s2_d       = s2_q;
        s2_valid_d = s2_valid_q;
        if (s2_load) begin
            s2_d.res   = core_res;
            s2_d.id    = s1_q.id;
            s2_valid_d = 1'b1;
        end else if (rsp_ready) begin
            s2_valid_d = 1'b0;
        end

        rr_ptr_d   = grant_any ? wrap_inc(gnt_idx, NUM_REQ) : rr_ptr_q;
        op_count_d = op_count_q + CNT_W'(s2_valid_q & rsp_ready);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q       <= '0;
            s2_q       <= '0;
            s2_valid_q <= 1'b0;
            rr_ptr_q   <= '0;
            op_count_q <= '0;
        end else begin
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s2_valid_q <= s2_valid_d;
            rr_ptr_q   <= rr_ptr_d;
            op_count_q <= op_count_d;
        end
    end

    assign req_ready = gnt;
    assign rsp_valid = s2_valid_q;
    assign rsp_res   = s2_q.res;
    assign rsp_id    = ID_W'(s2_q.id);
    assign busy      = s1_q.valid | s2_valid_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_mac_share_sched.sv
// Directed bench for mac_share_sched: single-operation vector table plus
// hand-written streaming, backpressure, reset and counter-wrap sequences.
module tb_mac_share_sched;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*8-1:0] req_a;
    logic [NUM_REQ*8-1:0] req_b;
    logic [NUM_REQ*16-1:0] req_m;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [16:0]          rsp_res;
    logic [ID_W-1:0]      rsp_id;
    logic                 busy;
    logic [CNT_W-1:0]     op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    typedef struct {
        int id;
        int a;
        int b;
        int m;
        int exp_res;
    } vec_t;

    vec_t vecs[8];
    int   stream_res[4];

    mac_share_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_m     (req_m),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_res   (rsp_res),
        .rsp_id    (rsp_id),
        .busy      (busy),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_op(input int id, input int a, input int b, input int m);
        case (id)
            0: begin req_a[7:0]   = 8'(a); req_b[7:0]   = 8'(b); req_m[15:0]  = 16'(m); end
            1: begin req_a[15:8]  = 8'(a); req_b[15:8]  = 8'(b); req_m[31:16] = 16'(m); end
            2: begin req_a[23:16] = 8'(a); req_b[23:16] = 8'(b); req_m[47:32] = 16'(m); end
            default: begin req_a[31:24] = 8'(a); req_b[31:24] = 8'(b); req_m[63:48] = 16'(m); end
        endcase
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        exp_cnt = 0;
        next_cycle();
    endtask

    initial begin
        vecs[0] = '{2,  12,  13,   100,    256};
        vecs[1] = '{0, 255, 255, 65535, 130560};
        vecs[2] = '{1,   0,   0,     0,      0};
        vecs[3] = '{3,   1,   1,     0,      1};
        vecs[4] = '{2, 255,   1,     0,    255};
        vecs[5] = '{1,  16,  16, 65535,  65791};
        vecs[6] = '{3, 100, 200,     7,  20007};
        vecs[7] = '{0, 255, 255,     0,  65025};
        stream_res = '{30, 1120, 2250, 3420};

        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_m     = '0;
        rsp_ready = 1'b1;
        #3;
        req_valid = 4'b0101;
        #1;
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_res",   32'(rsp_res),   0);
        check("reset_rsp_id",    32'(rsp_id),    0);
        check("reset_busy",      32'(busy),      0);
        check("reset_op_count",  32'(op_count),  0);
        check("reset_req_ready", 32'(req_ready), 0);
        req_valid = '0;
        #3;
        rst_n = 1'b1;
        next_cycle();

        // Single operations from the vector table, two-cycle latency each.
        for (int v = 0; v < 8; v++) begin
            set_op(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].m);
            req_valid = 4'(1 << vecs[v].id);
            @(negedge clk);
            check("single_grant", 32'(req_ready), 32'(1 << vecs[v].id));
            check("single_c0_rsp_valid", 32'(rsp_valid), 0);
            next_cycle();
            req_valid = '0;
            @(negedge clk);
            check("single_c1_rsp_valid", 32'(rsp_valid), 0);
            check("single_c1_busy", 32'(busy), 1);
            next_cycle();
            @(negedge clk);
            check("single_rsp_valid", 32'(rsp_valid), 1);
            check("single_rsp_res", 32'(rsp_res), 32'(vecs[v].exp_res));
            check("single_rsp_id", 32'(rsp_id), 32'(vecs[v].id));
            next_cycle();
            exp_cnt++;
            @(negedge clk);
            check("single_op_count", 32'(op_count), 32'(exp_cnt % 16));
            check("single_idle", 32'(busy), 0);
            next_cycle();
        end

        // Full-rate stream from all four requesters, 17 grants: 17 completions wrap the 4-bit counter to 1.
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) set_op(i, 10 + 20 * i, 3 + i, 1000 * i);
        req_valid = 4'hF;
        for (int n = 0; n < 19; n++) begin
            @(negedge clk);
            if (n < 17) check("stream_grant", 32'(req_ready), 32'(1 << (n % 4)));
            if (n >= 2) begin
                check("stream_rsp_valid", 32'(rsp_valid), 1);
                check("stream_rsp_id", 32'(rsp_id), 32'((n - 2) % 4));
                check("stream_rsp_res", 32'(rsp_res), 32'(stream_res[(n - 2) % 4]));
            end
            next_cycle();
            if (n == 16) req_valid = '0;
        end
        @(negedge clk);
        check("stream_drained", 32'(rsp_valid), 0);
        check("stream_busy", 32'(busy), 0);
        check("stream_op_count_wrap", 32'(op_count), 1);
        next_cycle();

        // Backpressure: two requests fill both stages, the third waits.
        apply_reset();
        rsp_ready = 1'b0;
        set_op(0, 2, 3, 4);
        set_op(1, 5, 6, 7);
        set_op(2, 200, 100, 50);
        req_valid = 4'b0111;
        @(negedge clk);
        check("bp_grant0", 32'(req_ready), 32'b0001);
        next_cycle();
        req_valid = 4'b0110;
        @(negedge clk);
        check("bp_grant1", 32'(req_ready), 32'b0010);
        check("bp_c1_rsp_valid", 32'(rsp_valid), 0);
        next_cycle();
        req_valid = 4'b0100;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_stall_ready", 32'(req_ready), 0);
            check("bp_stall_valid", 32'(rsp_valid), 1);
            check("bp_stall_res", 32'(rsp_res), 10);
            check("bp_stall_id", 32'(rsp_id), 0);
            check("bp_stall_busy", 32'(busy), 1);
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant2", 32'(req_ready), 32'b0100);
        check("bp_rsp0_res", 32'(rsp_res), 10);
        check("bp_rsp0_id", 32'(rsp_id), 0);
        next_cycle();
        req_valid = '0;
        @(negedge clk);
        check("bp_rsp1_valid", 32'(rsp_valid), 1);
        check("bp_rsp1_res", 32'(rsp_res), 37);
        check("bp_rsp1_id", 32'(rsp_id), 1);
        next_cycle();
        @(negedge clk);
        check("bp_rsp2_valid", 32'(rsp_valid), 1);
        check("bp_rsp2_res", 32'(rsp_res), 20050);
        check("bp_rsp2_id", 32'(rsp_id), 2);
        next_cycle();
        @(negedge clk);
        check("bp_done_valid", 32'(rsp_valid), 0);
        check("bp_op_count", 32'(op_count), 3);
        next_cycle();

        // Reset with both stages full; pointer sits at 3 after the previous sequence.
        rsp_ready = 1'b0;
        set_op(1, 9, 9, 9);
        set_op(3, 4, 4, 4);
        req_valid = 4'b1010;
        @(negedge clk);
        check("rst_pre_grant3", 32'(req_ready), 32'b1000);
        next_cycle();
        req_valid = 4'b0010;
        @(negedge clk);
        check("rst_pre_grant1", 32'(req_ready), 32'b0010);
        next_cycle();
        req_valid = 4'b1010;
        @(negedge clk);
        check("rst_pre_busy", 32'(busy), 1);
        check("rst_pre_rsp_valid", 32'(rsp_valid), 1);
        check("rst_pre_s1_full", 32'(req_ready), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_rsp_valid", 32'(rsp_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_op_count", 32'(op_count), 0);
        check("rst_mid_rr_ptr", 32'(dut.rr_ptr_q), 0);
        check("rst_mid_req_ready", 32'(req_ready), 0);
        check("rst_mid_rsp_res", 32'(rsp_res), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_after_grant_lowest", 32'(req_ready), 32'b0010);
        rsp_ready = 1'b1;
        next_cycle();
        req_valid = '0;
        next_cycle();
        @(negedge clk);
        check("rst_after_rsp_valid", 32'(rsp_valid), 1);
        check("rst_after_rsp_id", 32'(rsp_id), 1);
        check("rst_after_rsp_res", 32'(rsp_res), 90);
        next_cycle();
        @(negedge clk);
        check("rst_after_op_count", 32'(op_count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
